controlador_memoria_datos: RTL and testbench



---
 rtl/controlador_memoria_datos_pkg.sv | 36 +++
 rtl/controlador_memoria_datos_alineador.sv | 56 +++++
 rtl/controlador_memoria_datos.sv | 162 ++++++++++++++++
 tb/tb_controlador_memoria_datos.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/controlador_memoria_datos_pkg.sv
// Shared definitions for the data-memory load/store controller:
// access-size encodings, FSM state encodings and the alignment rule.
package controlador_memoria_datos_pkg;

    localparam int ANCHO_DATO_DEF    = 32;
    localparam int ANCHO_DIR_PAL_DEF = 8;

    typedef enum logic [1:0] {
        TAM_BYTE = 2'b00,
        TAM_HALF = 2'b01,
        TAM_WORD = 2'b10,
        TAM_RES  = 2'b11
    } tam_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEER = 3'd1,
        CAPT = 3'd2,
        ESCR = 3'd3,
        FIN  = 3'd4
    } estado_t;

    // An access is rejected when its size is reserved or its byte offset is
    // not a multiple of the access size.
    function automatic logic acceso_invalido(input tam_t tam, input logic [1:0] lane);
        logic inval;
        case (tam)
            TAM_BYTE: inval = 1'b0;
            TAM_HALF: inval = lane[0];
            TAM_WORD: inval = (lane != 2'b00);
            default:  inval = 1'b1;
        endcase
        return inval;
    endfunction

endpackage

// File: rtl/controlador_memoria_datos_alineador.sv
// Combinational lane handling: extracts the addressed byte/half of a memory
// word and extends it for loads, and merges store data into the addressed
// lane for read-modify-write stores. Byte k occupies bits 8k+7:8k.
module alineador_bytes
    import controlador_memoria_datos_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF
) (
    input  logic [ANCHO_DATO-1:0] palabra,
    input  logic [1:0]            lane,
    input  tam_t                  tam,
    input  logic                  con_signo,
    input  logic [15:0]           dato_sub,
    output logic [ANCHO_DATO-1:0] extendido,
    output logic [ANCHO_DATO-1:0] mezcla
);

    logic [7:0]            byte_s;
    logic [15:0]           media_s;
    logic [4:0]            desp_s;
    logic [ANCHO_DATO-1:0] mascara_s;
    logic [ANCHO_DATO-1:0] insercion_s;

    // Load path: pick the addressed lane and sign- or zero-extend it
    always_comb begin
        byte_s  = palabra[{lane, 3'b000} +: 8];
        media_s = palabra[{lane[1], 4'b0000} +: 16];
        case (tam)
            TAM_BYTE: extendido = {{(ANCHO_DATO-8){con_signo & byte_s[7]}}, byte_s};
            TAM_HALF: extendido = {{(ANCHO_DATO-16){con_signo & media_s[15]}}, media_s};
            TAM_WORD: extendido = palabra;
            default:  extendido = {ANCHO_DATO{1'b0}};
        endcase
    end

    // Store path: overwrite only the addressed lane of the word read back
    always_comb begin
        desp_s = {lane, 3'b000};
        case (tam)
            TAM_BYTE: begin
                mascara_s   = {{(ANCHO_DATO-8){1'b0}}, 8'hFF} << desp_s;
                insercion_s = {{(ANCHO_DATO-8){1'b0}}, dato_sub[7:0]} << desp_s;
            end
            TAM_HALF: begin
                mascara_s   = {{(ANCHO_DATO-16){1'b0}}, 16'hFFFF} << desp_s;
                insercion_s = {{(ANCHO_DATO-16){1'b0}}, dato_sub} << desp_s;
            end
            default: begin
                mascara_s   = {ANCHO_DATO{1'b0}};
                insercion_s = {ANCHO_DATO{1'b0}};
            end
        endcase
        mezcla = (palabra & ~mascara_s) | insercion_s;
    end

endmodule

// File: rtl/controlador_memoria_datos.sv
// Load/store initiator between the CPU datapath and a word-wide data memory
// with registered read data. Sub-word stores run as read-modify-write; loads
// are zero- or sign-extended. All outputs are registered.
module controlador_memoria_datos
    import controlador_memoria_datos_pkg::*;
#(
    parameter int ANCHO_DATO    = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR_PAL = ANCHO_DIR_PAL_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic                     we,
    input  logic [1:0]               tam,
    input  logic                     con_signo,
    input  logic [ANCHO_DIR_PAL+1:0] dir,
    input  logic [ANCHO_DATO-1:0]    dato_in,
    output logic                     ready,
    output logic                     done,
    output logic                     err,
    output logic [ANCHO_DATO-1:0]    dato_out,
    output logic                     EscrMem,
    output logic                     LeerMem,
    output logic [ANCHO_DIR_PAL-1:0] Direc,
    output logic [ANCHO_DATO-1:0]    DatoEscr,
    input  logic [ANCHO_DATO-1:0]    DatoLeido
);

    estado_t                  estado_r, estado_sig_s;
    logic                     acepta_s, invalido_s;
    logic                     we_r, signo_r;
    tam_t                     tam_r;
    logic [1:0]               lane_r;
    logic [15:0]              dato_r;
    logic [ANCHO_DIR_PAL-1:0] direc_r;
    logic [ANCHO_DATO-1:0]    dato_escr_r, dato_out_r;
    logic [ANCHO_DATO-1:0]    extendido_s, mezcla_s;
    logic                     ready_s, done_s, err_s, escr_s, leer_s;
    logic                     ready_r, done_r, err_r, escr_r, leer_r;

    assign acepta_s   = (estado_r == IDLE) & req;
    assign invalido_s = acceso_invalido(tam_t'(tam), dir[1:0]);

    alineador_bytes #(.ANCHO_DATO(ANCHO_DATO)) u_alineador (
        .palabra   (DatoLeido),
        .lane      (lane_r),
        .tam       (tam_r),
        .con_signo (signo_r),
        .dato_sub  (dato_r),
        .extendido (extendido_s),
        .mezcla    (mezcla_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= IDLE;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Next-state logic: word stores skip the read, sub-word stores read first
    always_comb begin
        estado_sig_s = IDLE;
        case (estado_r)
            IDLE: begin
                if (!acepta_s) begin
                    estado_sig_s = IDLE;
                end else if (invalido_s) begin
                    estado_sig_s = FIN;
                end else if (we && (tam_t'(tam) == TAM_WORD)) begin
                    estado_sig_s = ESCR;
                end else begin
                    estado_sig_s = LEER;
                end
            end
            LEER: estado_sig_s = CAPT;
            CAPT: begin
                if (we_r) begin
                    estado_sig_s = ESCR;
                end else begin
                    estado_sig_s = FIN;
                end
            end
            ESCR:    estado_sig_s = FIN;
            FIN:     estado_sig_s = IDLE;
            default: estado_sig_s = IDLE;
        endcase
    end

    // Output decode from the state being entered, so the registered outputs
    // line up with the state; only the error path goes straight IDLE->FIN
    always_comb begin
        ready_s = (estado_sig_s == IDLE);
        leer_s  = (estado_sig_s == LEER);
        escr_s  = (estado_sig_s == ESCR);
        done_s  = (estado_sig_s == FIN);
        err_s   = (estado_r == IDLE) && (estado_sig_s == FIN);
    end

    // Output strobe registers, cleared asynchronously so strobes drop at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b1;
            leer_r  <= 1'b0;
            escr_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= ready_s;
            leer_r  <= leer_s;
            escr_r  <= escr_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    // Request latching, memory address/data and load result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r        <= 1'b0;
            tam_r       <= TAM_BYTE;
            signo_r     <= 1'b0;
            lane_r      <= 2'b00;
            dato_r      <= 16'h0000;
            direc_r     <= {ANCHO_DIR_PAL{1'b0}};
            dato_escr_r <= {ANCHO_DATO{1'b0}};
            dato_out_r  <= {ANCHO_DATO{1'b0}};
        end else if (acepta_s) begin
            we_r    <= we;
            tam_r   <= tam_t'(tam);
            signo_r <= con_signo;
            lane_r  <= dir[1:0];
            dato_r  <= dato_in[15:0];
            direc_r <= dir[ANCHO_DIR_PAL+1:2];
            if (we && !invalido_s && (tam_t'(tam) == TAM_WORD)) begin
                dato_escr_r <= dato_in;
            end else begin
                dato_escr_r <= dato_escr_r;
            end
        end else if (estado_r == CAPT) begin
            if (we_r) begin
                dato_escr_r <= mezcla_s;
            end else begin
                dato_out_r <= extendido_s;
            end
        end else begin
            dato_out_r <= dato_out_r;
        end
    end

    assign ready    = ready_r;
    assign done     = done_r;
    assign err      = err_r;
    assign dato_out = dato_out_r;
    assign EscrMem  = escr_r;
    assign LeerMem  = leer_r;
    assign Direc    = direc_r;
    assign DatoEscr = dato_escr_r;

endmodule

// File: tb/tb_controlador_memoria_datos.sv
// Bench for the data-memory controller: a behavioural word memory with
// registered reads, a scoreboard of expected completions and directed ops.
module tb_controlador_memoria_datos;
    import controlador_memoria_datos_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, con_signo;
    logic [1:0]  tam;
    logic [9:0]  dir;
    logic [31:0] dato_in;
    logic        ready, done, err;
    logic [31:0] dato_out;
    logic        EscrMem, LeerMem;
    logic [7:0]  Direc;
    logic [31:0] DatoEscr;
    logic [31:0] DatoLeido;

    logic [31:0] mem [0:255];

    typedef struct {
        logic [31:0] dato;
        logic        err;
        int          lat;
        int          leer;
        int          escr;
    } esp_t;

    esp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ult_carga = 32'h0;

    controlador_memoria_datos dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .tam       (tam),
        .con_signo (con_signo),
        .dir       (dir),
        .dato_in   (dato_in),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .dato_out  (dato_out),
        .EscrMem   (EscrMem),
        .LeerMem   (LeerMem),
        .Direc     (Direc),
        .DatoEscr  (DatoEscr),
        .DatoLeido (DatoLeido)
    );

    always #5 clk = ~clk;

    // Memory model: write and read sample on posedge, read data registered
    always @(posedge clk) begin
        if (EscrMem) mem[Direc] <= DatoEscr;
        if (LeerMem) DatoLeido <= mem[Direc];
    end

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s obs=%h esp=%h", tag, obs, esp);
        end
    endtask

    // One operation: drive, push expectation, watch strobes until done, pop and compare
    task automatic op(input logic w, input logic [1:0] t, input logic s, input logic [9:0] d,
                      input logic [31:0] di, input logic [31:0] dato_esp, input logic err_esp,
                      input int lat_esp, input int leer_esp, input int escr_esp, input logic mantener);
        esp_t e;
        int   nl = 0, ne = 0, ambos = 0, lat = 0;
        logic fin = 1'b0;
        logic [31:0] obs_dato = 32'h0;
        logic        obs_err = 1'b0;
        @(negedge clk);
        comprobar("ready_antes", {31'h0, ready}, 32'h1);
        we = w; tam = t; con_signo = s; dir = d; dato_in = di; req = 1'b1;
        if (!w && !err_esp) ult_carga = dato_esp;
        e.dato = ult_carga; e.err = err_esp; e.lat = lat_esp; e.leer = leer_esp; e.escr = escr_esp;
        sb.push_back(e);
        for (int k = 1; k <= 12 && !fin; k++) begin
            @(negedge clk);
            if (!mantener) req = 1'b0;
            if (k == 1) begin
                we = ~w; tam = ~t; con_signo = ~s; dir = ~d; dato_in = ~di;
            end
            if (LeerMem) nl++;
            if (EscrMem) ne++;
            if (LeerMem && EscrMem) ambos++;
            if (done) begin
                fin = 1'b1; lat = k; obs_dato = dato_out; obs_err = err;
            end
        end
        req = mantener;
        e = sb.pop_front();
        comprobar("latencia", lat, e.lat);
        comprobar("err", {31'h0, obs_err}, {31'h0, e.err});
        comprobar("dato_out", obs_dato, e.dato);
        comprobar("n_leer", nl, e.leer);
        comprobar("n_escr", ne, e.escr);
        comprobar("strobes_juntos", ambos, 0);
    endtask

    initial begin
        int nl;
        #200000;
        $display("FAIL watchdog obs=timeout esp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, ne;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; tam = 2'b00; con_signo = 1'b0;
        dir = 10'h0; dato_in = 32'h0;
        @(negedge clk); @(negedge clk);
        comprobar("rst_ready", {31'h0, ready}, 32'h1);
        comprobar("rst_done", {31'h0, done}, 32'h0);
        comprobar("rst_err", {31'h0, err}, 32'h0);
        comprobar("rst_escr", {31'h0, EscrMem}, 32'h0);
        comprobar("rst_leer", {31'h0, LeerMem}, 32'h0);
        comprobar("rst_direc", {24'h0, Direc}, 32'h0);
        comprobar("rst_datoescr", DatoEscr, 32'h0);
        comprobar("rst_datoout", dato_out, 32'h0);
        rst_n = 1'b1;

        // 1: word store then word load
        op(1'b1, TAM_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 1'b0);
        comprobar("direc_t1", {24'h0, Direc}, 32'h04);
        comprobar("mem_t1", mem[8'h04], 32'hDEADBEEF);
        op(1'b0, TAM_WORD, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 1'b0);

        // 2: sub-word loads with and without sign extension
        op(1'b1, TAM_WORD, 1'b0, 10'h010, 32'h80FF1234, 32'h0, 1'b0, 2, 0, 1, 1'b0);
        op(1'b0, TAM_BYTE, 1'b1, 10'h013, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1, 0, 1'b0);
        op(1'b0, TAM_BYTE, 1'b0, 10'h013, 32'h0, 32'h00000080, 1'b0, 3, 1, 0, 1'b0);
        op(1'b0, TAM_HALF, 1'b1, 10'h012, 32'h0, 32'hFFFF80FF, 1'b0, 3, 1, 0, 1'b0);
        op(1'b0, TAM_HALF, 1'b0, 10'h010, 32'h0, 32'h00001234, 1'b0, 3, 1, 0, 1'b0);
        op(1'b0, TAM_BYTE, 1'b1, 10'h011, 32'h0, 32'h00000012, 1'b0, 3, 1, 0, 1'b0);
        op(1'b0, TAM_WORD, 1'b1, 10'h010, 32'h0, 32'h80FF1234, 1'b0, 3, 1, 0, 1'b0);

        // 3: read-modify-write stores
        op(1'b1, TAM_WORD, 1'b0, 10'h010, 32'h11223344, 32'h0, 1'b0, 2, 0, 1, 1'b0);
        op(1'b1, TAM_HALF, 1'b0, 10'h012, 32'h0000ABCD, 32'h0, 1'b0, 4, 1, 1, 1'b0);
        comprobar("mem_half", mem[8'h04], 32'hABCD3344);
        op(1'b1, TAM_BYTE, 1'b0, 10'h011, 32'h12345677, 32'h0, 1'b0, 4, 1, 1, 1'b0);
        comprobar("mem_byte", mem[8'h04], 32'hABCD7744);
        op(1'b0, TAM_WORD, 1'b0, 10'h010, 32'h0, 32'hABCD7744, 1'b0, 3, 1, 0, 1'b0);

        // 4: misaligned and reserved-size requests
        op(1'b0, TAM_WORD, 1'b0, 10'h011, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        op(1'b0, TAM_RES, 1'b0, 10'h000, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        op(1'b1, TAM_HALF, 1'b0, 10'h013, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        comprobar("mem_err", mem[8'h04], 32'hABCD7744);

        // 5: reset during the write phase of a read-modify-write
        op(1'b1, TAM_WORD, 1'b0, 10'h080, 32'h11111111, 32'h0, 1'b0, 2, 0, 1, 1'b0);
        @(negedge clk);
        we = 1'b1; tam = TAM_BYTE; con_signo = 1'b0; dir = 10'h080; dato_in = 32'h000000AA; req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req = 1'b0;
        end
        comprobar("escr_antes_rst", {31'h0, EscrMem}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        comprobar("escr_async", {31'h0, EscrMem}, 32'h0);
        comprobar("rst2_leer", {31'h0, LeerMem}, 32'h0);
        comprobar("rst2_done", {31'h0, done}, 32'h0);
        comprobar("rst2_err", {31'h0, err}, 32'h0);
        comprobar("rst2_direc", {24'h0, Direc}, 32'h0);
        comprobar("rst2_datoescr", DatoEscr, 32'h0);
        comprobar("rst2_datoout", dato_out, 32'h0);
        comprobar("rst2_ready", {31'h0, ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ult_carga = 32'h0;
        comprobar("mem_rst", mem[8'h20], 32'h11111111);

        // 6: req held high across two operations
        op(1'b1, TAM_WORD, 1'b0, 10'h020, 32'h0BADF00D, 32'h0, 1'b0, 2, 0, 1, 1'b1);
        op(1'b0, TAM_WORD, 1'b0, 10'h020, 32'h0, 32'h0BADF00D, 1'b0, 3, 1, 0, 1'b0);
        comprobar("mem_t6", mem[8'h08], 32'h0BADF00D);
        nl = 0; ne = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (LeerMem) nl++;
            if (EscrMem) ne++;
        end
        comprobar("sin_tercera_leer", nl, 0);
        comprobar("sin_tercera_escr", ne, 0);
        comprobar("sb_vacio", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
